// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser and its payload buffer.
package uart_frame_pkg;

   localparam int unsigned CHK_W       = 8;
   localparam logic [7:0]  SOF_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_DRAIN
   } state_t;

endpackage

// File: rtl/frame_buf.sv
// Single-frame payload store: one synchronous write port, one combinational read port.
module frame_buf #(
   parameter int unsigned D_BITS  = 8,
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned IDX_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [D_BITS-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [D_BITS-1:0] o_rdata_c
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [D_BITS-1:0] mem_q [MAX_LEN];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[AW'(i_waddr)] <= i_wdata;
      end
   end

   // Reads past the end of the array (one beyond the last beat) return zero.
   always_comb begin
      o_rdata_c = '0;
      if (32'(i_raddr) < MAX_LEN) begin
         o_rdata_c = mem_q[AW'(i_raddr)];
      end
   end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SOF/LEN/payload/CHK frames from a UART byte strobe and drains the payload over valid/ready.
// Optional inter-byte timeout enabled by defining UART_FRAME_PARSER_TIMEOUT_EN.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int unsigned D_BITS         = 8,
   parameter int unsigned MAX_LEN        = 16,
   parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 8680
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [D_BITS-1:0] i_data,
   input  logic              i_rx_done,
   output logic [D_BITS-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_last,
   output logic              o_frame_ok,
   output logic              o_frame_err,
   output logic              o_overrun
);

   state_t            state_q, state_d;
   logic [CHK_W-1:0]  len_q, len_d;
   logic [CHK_W-1:0]  cnt_q, cnt_d;
   logic [CHK_W-1:0]  acc_q, acc_d;
   logic [CHK_W-1:0]  rd_idx_q, rd_idx_d;
   logic [D_BITS-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              ok_q, ok_d;
   logic              err_q, err_d;
   logic              ovr_q, ovr_d;

   logic              buf_we_c;
   logic [CHK_W-1:0]  rd_addr_c;
   logic [D_BITS-1:0] rd_data_c;
   logic [CHK_W-1:0]  byte_c;
   logic [CHK_W-1:0]  sum_c;
   logic              is_sof_c;
   logic              hs_c;
   logic              timeout_c;

   assign byte_c   = CHK_W'(i_data);
   assign sum_c    = acc_q + byte_c;
   assign is_sof_c = i_rx_done && (i_data == D_BITS'(SOF_BYTE));
   assign hs_c     = valid_q && i_ready;

   // Read address looks one beat ahead so the next o_data is ready at the handshake.
   assign rd_addr_c = (state_q == S_DRAIN) ? rd_idx_q + CHK_W'(1) : '0;

   frame_buf #(
      .D_BITS  (D_BITS),
      .MAX_LEN (MAX_LEN),
      .IDX_W   (CHK_W)
   ) u_buf (
      .i_clk     (i_clk),
      .i_we      (buf_we_c),
      .i_waddr   (cnt_q),
      .i_wdata   (i_data),
      .i_raddr   (rd_addr_c),
      .o_rdata_c (rd_data_c)
   );

`ifdef UART_FRAME_PARSER_TIMEOUT_EN
   localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [GAP_W-1:0] gap_q, gap_d;

   // Idle-gap counter runs only while a frame is partially received.
   always_comb begin
      gap_d     = '0;
      timeout_c = 1'b0;
      if ((state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK)) begin
         if (!i_rx_done) begin
            if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_c = 1'b1;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`else
   logic [31:0] unused_timeout_c;

   assign unused_timeout_c = 32'(TIMEOUT_CYCLES);
   assign timeout_c        = 1'b0;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      rd_idx_d = rd_idx_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      ok_d     = 1'b0;
      err_d    = 1'b0;
      ovr_d    = 1'b0;
      buf_we_c = 1'b0;

      unique case (state_q)
         S_HUNT: begin
            if (is_sof_c) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (i_rx_done) begin
               if ((byte_c == '0) || (byte_c > CHK_W'(MAX_LEN))) begin
                  err_d   = 1'b1;
                  state_d = S_HUNT;
               end else begin
                  len_d   = byte_c;
                  acc_d   = byte_c;
                  cnt_d   = '0;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (i_rx_done) begin
               buf_we_c = 1'b1;
               acc_d    = sum_c;
               cnt_d    = cnt_q + CHK_W'(1);
               if (cnt_d == len_q) begin
                  state_d = S_CHK;
               end
            end
         end
         S_CHK: begin
            if (i_rx_done) begin
               if (sum_c == '0) begin
                  ok_d     = 1'b1;
                  state_d  = S_DRAIN;
                  valid_d  = 1'b1;
                  rd_idx_d = '0;
                  data_d   = rd_data_c;
                  last_d   = (len_q == CHK_W'(1));
               end else begin
                  err_d   = 1'b1;
                  state_d = S_HUNT;
               end
            end
         end
         S_DRAIN: begin
            // The final handshake frees the parser, so a coincident byte is hunted, not dropped.
            if (hs_c && last_q) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = is_sof_c ? S_LEN : S_HUNT;
            end else begin
               ovr_d = i_rx_done;
               if (hs_c) begin
                  rd_idx_d = rd_idx_q + CHK_W'(1);
                  data_d   = rd_data_c;
                  last_d   = (rd_idx_d == len_q - CHK_W'(1));
               end
            end
         end
         default: begin
            state_d = S_HUNT;
         end
      endcase

      if (timeout_c) begin
         err_d   = 1'b1;
         state_d = S_HUNT;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_HUNT;
         len_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         rd_idx_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         rd_idx_q <= rd_idx_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_last      = last_q;
   assign o_frame_ok  = ok_q;
   assign o_frame_err = err_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expectations queued at stimulus time, popped by a negedge monitor.
module tb_uart_frame_parser;

   localparam int EV_OK  = 1;
   localparam int EV_ERR = 2;
   localparam int EV_OVR = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       rx_done;
   logic       ready;
   logic [7:0] dout;
   logic       valid, last, f_ok, f_err, ovr;

   always #5 clk = ~clk;

   uart_frame_parser #(
      .D_BITS         (8),
      .MAX_LEN        (16),
      .SOF_BYTE       (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_data      (din),
      .i_rx_done   (rx_done),
      .o_data      (dout),
      .o_valid     (valid),
      .i_ready     (ready),
      .o_last      (last),
      .o_frame_ok  (f_ok),
      .o_frame_err (f_err),
      .o_overrun   (ovr)
   );

   int         n_total = 0;
   int         n_pass  = 0;
   logic [8:0] beat_q[$];
   int         ev_q[$];
   logic [7:0] pl[$];
   logic       ready_rand = 1'b0;
   logic       pre_valid;

   function automatic void chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void pop_ev(input int code);
      chk("pulse_expected", int'(ev_q.size() > 0), 1);
      if (ev_q.size() > 0) chk("pulse_kind", code, ev_q.pop_front());
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(posedge clk);
      #1;
      din     = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
   endtask

   // Reference: checksum makes (LEN + payload + CHK) mod 256 zero; good frames yield every payload byte in order.
   task automatic send_frame(input bit good, input int maxgap);
      int s;
      int len;
      int ck;
      len = pl.size();
      s   = len;
      foreach (pl[i]) s += int'(pl[i]);
      ck = (256 - (s % 256)) % 256;
      if (!good) ck = (ck + 1 + int'($urandom_range(0, 254))) % 256;
      if (good) begin
         ev_q.push_back(EV_OK);
         foreach (pl[i]) beat_q.push_back({(i == len - 1), pl[i]});
      end else begin
         ev_q.push_back(EV_ERR);
      end
      send_byte(8'hA5, $urandom_range(0, maxgap));
      send_byte(8'(len), $urandom_range(0, maxgap));
      foreach (pl[i]) send_byte(pl[i], $urandom_range(0, maxgap));
      pre_valid = valid;
      send_byte(8'(ck), $urandom_range(0, maxgap));
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((beat_q.size() != 0 || ev_q.size() != 0 || valid) && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain_in_budget", int'(k < 3000), 1);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_rand) ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pulses, delivered beats and stall stability.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;
   always @(negedge clk) begin
      int np;
      logic [8:0] b;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         np = int'(f_ok) + int'(f_err) + int'(ovr);
         if (np > 1) chk("pulse_exclusive", np, 1);
         if (f_ok)  pop_ev(EV_OK);
         if (f_err) pop_ev(EV_ERR);
         if (ovr)   pop_ev(EV_OVR);
         if (prev_stall) begin
            chk("stall_valid", int'(valid), 1);
            chk("stall_data", int'(dout), int'(prev_data));
            chk("stall_last", int'(last), int'(prev_last));
         end
         if (valid && ready) begin
            chk("beat_expected", int'(beat_q.size() > 0), 1);
            if (beat_q.size() > 0) begin
               b = beat_q.pop_front();
               chk("beat_data", int'(dout), int'(b[7:0]));
               chk("beat_last", int'(last), int'(b[8]));
            end
         end
         prev_stall = valid && !ready;
         prev_data  = dout;
         prev_last  = last;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int k;
      logic [7:0] b;
      rst = 1'b1; din = 8'h00; rx_done = 1'b0; ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(valid), 0);
      chk("rst_data", int'(dout), 0);
      chk("rst_last", int'(last), 0);
      chk("rst_pulses", int'({f_ok, f_err, ovr}), 0);
      rst = 1'b0;

      // Good frame A5 03 11 22 33 97 with ready high.
      pl = '{8'h11, 8'h22, 8'h33};
      send_frame(1'b1, 0);
      chk("valid_before_chk", int'(pre_valid), 0);
      chk("valid_latency", int'(valid), 1);
      chk("frame_ok_latency", int'(f_ok), 1);
      wait_drain();

      // Bad checksum A5 02 01 02 00, then a good frame.
      ev_q.push_back(EV_ERR);
      send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h01, 1);
      send_byte(8'h02, 1); send_byte(8'h00, 1);
      chk("badchk_err", int'(f_err), 1);
      repeat (3) @(posedge clk);
      #1 chk("badchk_no_valid", int'(valid), 0);
      pl = '{8'hC3, 8'hA5};
      send_frame(1'b1, 2);
      wait_drain();

      // Bad lengths 0 and MAX_LEN+1.
      ev_q.push_back(EV_ERR);
      send_byte(8'hA5, 1); send_byte(8'h00, 1);
      chk("len0_err", int'(f_err), 1);
      ev_q.push_back(EV_ERR);
      send_byte(8'hA5, 1); send_byte(8'h11, 1);
      chk("len17_err", int'(f_err), 1);
      wait_drain();

      // Backpressure with a byte dropped during the stall.
      ready = 1'b0;
      pl = '{8'h10, 8'h20};
      send_frame(1'b1, 1);
      repeat (10) @(posedge clk);
      ev_q.push_back(EV_OVR);
      send_byte(8'h5A, 0);
      chk("bp_overrun", int'(ovr), 1);
      chk("bp_data_held", int'(dout), 8'h10);
      repeat (38) @(posedge clk);
      #1 ready = 1'b1;
      wait_drain();

      // Last-beat handshake coincident with an SOF strobe.
      ready = 1'b0;
      pl = '{8'h44};
      send_frame(1'b1, 1);
      k = 0;
      while (!valid && k < 50) begin @(posedge clk); #1; k++; end
      chk("coinc_valid_seen", int'(valid), 1);
      repeat (2) @(posedge clk);
      #1;
      ready = 1'b1; din = 8'hA5; rx_done = 1'b1;
      @(posedge clk);
      #1 rx_done = 1'b0;
      chk("coinc_no_overrun", int'(ovr), 0);
      chk("coinc_valid_low", int'(valid), 0);
      ev_q.push_back(EV_OK);
      beat_q.push_back({1'b1, 8'h7F});
      send_byte(8'h01, 1); send_byte(8'h7F, 1); send_byte(8'h80, 1);
      wait_drain();

      // Partial frame followed by a long idle gap.
      send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h11, 1);
`ifdef UART_FRAME_PARSER_TIMEOUT_EN
      ev_q.push_back(EV_ERR);
      repeat (98) @(posedge clk);
      #1 chk("timeout_not_early", int'(f_err), 0);
      repeat (2) @(posedge clk);
      #1 chk("timeout_err", int'(f_err), 1);
      repeat (50) @(posedge clk);
`else
      repeat (150) @(posedge clk);
      #1 chk("no_timeout_err", int'(f_err), 0);
      ev_q.push_back(EV_OK);
      beat_q.push_back({1'b0, 8'h11});
      beat_q.push_back({1'b1, 8'h22});
`endif
      send_byte(8'h22, 1); send_byte(8'hCB, 1);
      wait_drain();

      // Reset in the middle of a frame aborts it silently.
      send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h01, 1);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_valid", int'(valid), 0);
      rst = 1'b0;

      // Randomized frames with random downstream readiness.
      ready_rand = 1'b1;
      for (int it = 0; it < 40; it++) begin
         int kind;
         int len;
         kind = int'($urandom_range(0, 9));
         for (int n = int'($urandom_range(0, 2)); n > 0; n--) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, $urandom_range(0, 3));
         end
         if (kind <= 7) begin
            len = int'($urandom_range(1, 16));
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
            send_frame(kind <= 5, 3);
         end else begin
            ev_q.push_back(EV_ERR);
            send_byte(8'hA5, $urandom_range(0, 3));
            send_byte((kind == 8) ? 8'h00 : 8'($urandom_range(17, 255)), $urandom_range(0, 3));
         end
         wait_drain();
      end

      ready_rand = 1'b0;
      ready = 1'b1;
      wait_drain();
      chk("beats_left", beat_q.size(), 0);
      chk("events_left", ev_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receive top. Consumes its byte strobe (o_data/o_rx_done) and extracts framed, checksummed packets.
- Buffers one frame's payload and streams it out over a valid/ready interface with a last marker.
- Flags malformed frames and bytes dropped while the output is draining.

Parameters:
- D_BITS, 8, byte width; must match the receiver.
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- SOF_BYTE, 8'hA5, start-of-frame marker.
- TIMEOUT_CYCLES, 8680, inter-byte timeout in i_clk cycles; used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_data  in  D_BITS  received byte; valid when i_rx_done=1.
- i_rx_done  in  1  single-cycle byte strobe from the receiver.
- o_data  out  D_BITS  payload byte.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts; a beat transfers when o_valid & i_ready.
- o_last  out  1  marks the final payload byte of a frame.
- o_frame_ok  out  1  one-cycle pulse: good frame accepted.
- o_frame_err  out  1  one-cycle pulse: bad length, bad checksum or timeout.
- o_overrun  out  1  one-cycle pulse: byte dropped during DRAIN.

Behaviour:
- Frame format: SOF, LEN, LEN payload bytes, CHK.
  - CHK is chosen so that (LEN + sum of payload + CHK) mod 256 == 0.
  - All checksum arithmetic is 8-bit with wrap-around.
- Reset: state=HUNT; o_valid, o_last, o_frame_ok, o_frame_err, o_overrun = 0; o_data = 0; byte counter and checksum accumulator = 0.
- A byte is processed only in a cycle with i_rx_done=1. No input backpressure exists.
- States and transitions:
  - HUNT: byte == SOF_BYTE -> LEN. Any other byte is discarded silently.
  - LEN: byte == 0 or byte > MAX_LEN -> pulse o_frame_err, go to HUNT. Otherwise latch the length, seed the accumulator with it, clear the counter, go to PAYLOAD.
  - PAYLOAD: write the byte to buffer[counter], add it to the accumulator, increment the counter. When counter reaches LEN, go to CHK.
  - CHK: if (accumulator + byte) mod 256 == 0, pulse o_frame_ok and go to DRAIN. Otherwise pulse o_frame_err and go to HUNT; the buffer contents are abandoned.
  - DRAIN: o_valid=1 with o_data=buffer[rd_idx]. rd_idx advances on each handshake. o_last=1 when rd_idx == LEN-1. The handshake on the last beat returns to HUNT.
- Latency: o_valid rises the cycle after the CHK byte strobe.
- Output stability: o_data and o_last stay stable while o_valid & !i_ready.
- Bytes arriving in DRAIN: each strobe pulses o_overrun and the byte is dropped. The parser does not resync mid-drain.
- Last-beat handshake coinciding with i_rx_done: that byte is evaluated as a HUNT byte in the same cycle, so an SOF is accepted and the next state is LEN. No o_overrun is raised.
- SOF_BYTE value inside LEN, PAYLOAD or CHK is treated as data, not as a resync.
- i_rst in any state: aborts immediately to reset values, with no pulses in that cycle.
- Pulse outputs are mutually exclusive per cycle and never held longer than 1 cycle.

Optional Feature:
- Macro: UART_FRAME_PARSER_TIMEOUT_EN.
- Defined:
  - A gap counter clears on every i_rx_done and increments otherwise while in LEN, PAYLOAD or CHK.
  - When the counter reaches TIMEOUT_CYCLES: pulse o_frame_err and go to HUNT.
  - The counter is inactive in HUNT and DRAIN.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter exists; a partial frame waits indefinitely for more bytes.

Decomposition:
- Package uart_frame_pkg:
  - state enum typedef (HUNT, LEN, PAYLOAD, CHK, DRAIN);
  - default SOF constant 8'hA5;
  - checksum width constant (8).
- Sub-module frame_buf: MAX_LEN x D_BITS register array, one synchronous write port, one combinational read port. The parser owns all indices.

Test Plan:
- Good frame: A5 03 11 22 33 97 with i_ready=1 -> o_frame_ok pulse; beats 11, 22, 33; o_last only on 33; o_valid rises the cycle after the 97 strobe.
- Bad checksum: A5 02 01 02 00 -> o_frame_err pulse; o_valid never asserts; next good frame parses correctly.
- Bad length: A5 00, and separately A5 11 with MAX_LEN=16 -> o_frame_err on the LEN byte; parser back in HUNT.
- Backpressure plus overrun: good 2-byte frame with i_ready held 0 for 50 cycles; inject byte 5A during that stall -> o_overrun pulse; o_data stable; both beats delivered after i_ready=1.
- Coincident events: last-beat handshake in the same cycle as an A5 strobe -> no o_overrun; the following LEN byte is accepted.
- Timeout (macro defined, TIMEOUT_CYCLES=100): A5 02 11 then idle for 100 cycles -> o_frame_err at the 100th idle cycle; HUNT. With the macro undefined, the same stimulus produces no error.
